pwm_hbridge_dt: RTL and testbench

//  Parametrised H-bridge PWM generator: converts a signed 2's-complement duty word into

---
 rtl/pwm_hbridge_dt_if.sv | 23 ++
 rtl/pwm_hbridge_dt.sv | 117 +++++++++++
 tb/tb_pwm_hbridge_dt.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_hbridge_dt_if.sv
// Controller-side bundle for the H-bridge PWM generator: duty write strobe,
// brake level and the registered bridge/status outputs.
interface pwm_hbridge_dt_if #(
    parameter int CNT_W = 13
);
    logic             wrt_duty;
    logic [CNT_W:0]   duty;
    logic             brake;
    logic             CH_A;
    logic             CH_B;
    logic             period_start;
    logic             pend_valid;

    modport master (
        output wrt_duty, duty, brake,
        input  CH_A, CH_B, period_start, pend_valid
    );

    modport slave (
        input  wrt_duty, duty, brake,
        output CH_A, CH_B, period_start, pend_valid
    );
endinterface

// File: rtl/pwm_hbridge_dt.sv
// H-bridge PWM generator: signed duty to complementary CH_A/CH_B drive with
// period-boundary double buffering, reversal dead time, saturation and brake.
module pwm_hbridge_dt #(
    parameter int CNT_W     = 13,
    parameter int DEAD_TIME = 64
) (
    input  logic             clk,
    input  logic             rst,
    pwm_hbridge_dt_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   DUTY_MIN = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W-1:0] DT_LOAD  = CNT_W'(DEAD_TIME);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dt_cnt;
    logic [CNT_W:0]   pend;
    logic [CNT_W:0]   act;
    logic             pend_valid_q;
    logic             last_dir;
    logic             has_run;
    logic             ch_a_q;
    logic             ch_b_q;
    logic             period_start_q;

    logic             load;
    logic [CNT_W:0]   load_val;
    logic [CNT_W-1:0] load_mag;
    logic             load_dir;
    logic             reversal;
    logic [CNT_W-1:0] act_mag;
    logic             act_dir;
    logic             on;

    // The most-negative duty has no positive twin; clamp it to full scale.
    function automatic logic [CNT_W-1:0] magnitude(input logic [CNT_W:0] d);
        logic [CNT_W:0] neg;
        neg = -d;
        if (!d[CNT_W])
            return d[CNT_W-1:0];
        else if (d == DUTY_MIN)
            return CNT_MAX;
        else
            return neg[CNT_W-1:0];
    endfunction

    always_comb begin
        load     = 1'b0;
        load_val = pend;
        load_mag = '0;
        load_dir = 1'b0;
        reversal = 1'b0;
        act_mag  = magnitude(act);
        act_dir  = act[CNT_W];
        on       = 1'b0;

        // A write landing on the last count bypasses the pending register.
        load_val = bus.wrt_duty ? bus.duty : pend;
        load     = (cnt == CNT_MAX) && (bus.wrt_duty || pend_valid_q);
        load_mag = magnitude(load_val);
        load_dir = load_val[CNT_W];
        reversal = load && (load_mag != '0) && has_run && (load_dir != last_dir);

        on = (cnt < act_mag) && (dt_cnt == '0) && !bus.brake;
    end

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            dt_cnt         <= '0;
            pend           <= '0;
            act            <= '0;
            pend_valid_q   <= 1'b0;
            last_dir       <= 1'b0;
            has_run        <= 1'b0;
            ch_a_q         <= 1'b0;
            ch_b_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt            <= cnt + 1'b1;
            period_start_q <= (cnt == '0);
            ch_a_q         <= on && !act_dir;
            ch_b_q         <= on && act_dir;

            if (bus.wrt_duty) begin
                pend         <= bus.duty;
                pend_valid_q <= 1'b1;
            end

            // Later assignment wins, so a load always clears pend_valid.
            if (load) begin
                act          <= load_val;
                pend_valid_q <= 1'b0;
                if (load_mag != '0) begin
                    last_dir <= load_dir;
                    has_run  <= 1'b1;
                end
            end

            if (reversal)
                dt_cnt <= DT_LOAD;
            else if (dt_cnt != '0)
                dt_cnt <= dt_cnt - 1'b1;
        end
    end

    assign bus.CH_A         = ch_a_q;
    assign bus.CH_B         = ch_b_q;
    assign bus.period_start = period_start_q;
    assign bus.pend_valid   = pend_valid_q;

    a_never_shoot_through: assert property (@(posedge clk) !(ch_a_q && ch_b_q));

endmodule

// File: tb/tb_pwm_hbridge_dt.sv
// Scoreboard bench for pwm_hbridge_dt at CNT_W=4, DEAD_TIME=2 (16-clock period).
module tb_pwm_hbridge_dt;

    localparam int CNT_W     = 4;
    localparam int DEAD_TIME = 2;
    localparam int PER       = 16;

    typedef struct packed {
        logic a;
        logic b;
        logic ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   tb_cnt       = 0;
    exp_t sb_q[$];

    pwm_hbridge_dt_if #(.CNT_W(CNT_W)) bus ();

    pwm_hbridge_dt #(
        .CNT_W    (CNT_W),
        .DEAD_TIME(DEAD_TIME)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; tb_cnt mirrors the value the counter holds afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        tb_cnt = rst ? 0 : (tb_cnt + 1) % PER;
    endtask

    task automatic wait_cnt(input int v);
        while (tb_cnt != v) tick();
    endtask

    task automatic write_duty(input logic [CNT_W:0] v);
        bus.wrt_duty = 1'b1;
        bus.duty     = v;
        tick();
        bus.wrt_duty = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act_v, input logic exp_v);
        tests_run++;
        if (act_v !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    // Starting at a period boundary, queue the expected outputs for n cycles,
    // then drive brake per cycle and compare every sample against the queue.
    task automatic run_window(input string name, input int n, input int mag, input bit dir,
                              input int dead, input int brk_lo, input int brk_hi);
        exp_t e;
        bit   on;
        int   k;
        for (int g = 0; g < n; g++) begin
            k    = g % PER;
            on   = (k < mag) && (g >= dead) && !(g >= brk_lo && g <= brk_hi);
            e.a  = on && !dir;
            e.b  = on && dir;
            e.ps = (k == 0);
            sb_q.push_back(e);
        end
        for (int g = 0; g < n; g++) begin
            bus.brake = (g >= brk_lo && g <= brk_hi);
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if ({bus.CH_A, bus.CH_B, bus.period_start} !== {e.a, e.b, e.ps}) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got a/b/ps=%b%b%b expected %b%b%b",
                         name, g, bus.CH_A, bus.CH_B, bus.period_start, e.a, e.b, e.ps);
            end
        end
        bus.brake = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_bit("reset_ch_a", bus.CH_A, 1'b0);
        check_bit("reset_ch_b", bus.CH_B, 1'b0);
        check_bit("reset_pend_valid", bus.pend_valid, 1'b0);
        check_bit("reset_period_start", bus.period_start, 1'b0);
        rst = 1'b0;
        tick();
        check_bit("first_period_start", bus.period_start, 1'b1);
    endtask

    task automatic test_write_load();
        wait_cnt(6);
        write_duty(5'sd5);
        check_bit("pend_valid_set", bus.pend_valid, 1'b1);
        wait_cnt(15);
        check_bit("pend_valid_held", bus.pend_valid, 1'b1);
        tick();
        check_bit("pend_valid_cleared", bus.pend_valid, 1'b0);
        run_window("fwd5", 2 * PER, 5, 1'b0, 0, 1, 0);
    endtask

    task automatic test_reversal();
        wait_cnt(4);
        write_duty(5'b11101);
        wait_cnt(0);
        run_window("rev3_dead", PER, 3, 1'b1, DEAD_TIME, 1, 0);
        run_window("rev3_steady", PER, 3, 1'b1, 0, 1, 0);
    endtask

    task automatic test_saturation();
        wait_cnt(7);
        write_duty(5'b10000);
        wait_cnt(0);
        run_window("rev_sat", 2 * PER, 15, 1'b1, 0, 1, 0);
        wait_cnt(9);
        write_duty(5'sd15);
        wait_cnt(0);
        run_window("fwd15_dead", PER, 15, 1'b0, DEAD_TIME, 1, 0);
        run_window("fwd15_steady", PER, 15, 1'b0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        wait_cnt(15);
        write_duty(5'sd7);
        check_bit("bypass_pend_valid", bus.pend_valid, 1'b0);
        run_window("bypass7", PER, 7, 1'b0, 0, 1, 0);
        wait_cnt(3);
        write_duty(5'sd3);
        wait_cnt(8);
        write_duty(5'sd9);
        check_bit("two_writes_pend_valid", bus.pend_valid, 1'b1);
        wait_cnt(0);
        run_window("last_wins9", PER, 9, 1'b0, 0, 1, 0);
    endtask

    task automatic test_brake();
        wait_cnt(2);
        write_duty(5'sd10);
        wait_cnt(0);
        run_window("brake10", 2 * PER, 10, 1'b0, 0, 3, 20);
    endtask

    task automatic test_reset_mid();
        wait_cnt(4);
        check_bit("pre_reset_ch_a", bus.CH_A, 1'b1);
        rst          = 1'b1;
        bus.wrt_duty = 1'b1;
        bus.duty     = 5'sd6;
        tick();
        rst          = 1'b0;
        bus.wrt_duty = 1'b0;
        check_bit("midrst_ch_a", bus.CH_A, 1'b0);
        check_bit("midrst_ch_b", bus.CH_B, 1'b0);
        check_bit("midrst_pend_valid", bus.pend_valid, 1'b0);
        run_window("post_reset_idle", PER, 0, 1'b0, 0, 1, 0);
        wait_cnt(5);
        write_duty(5'b11100);
        wait_cnt(0);
        run_window("rev4_no_dead", PER, 4, 1'b1, 0, 1, 0);
    endtask

    initial begin
        bus.wrt_duty = 1'b0;
        bus.duty     = '0;
        bus.brake    = 1'b0;
        test_reset();
        test_write_load();
        test_reversal();
        test_saturation();
        test_back_to_back();
        test_brake();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
